serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master drives operands and consumes results; the slave is the subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned/two's-complement subtractor: one bit per clock, LSB first.
// Result appears WIDTH cycles after accept and is held until the consumer takes it.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                 clock,
    input logic                 reset,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic ai, bi, res_bit, bout;

    assign ai      = a_sr_q[0];
    assign bi      = b_sr_q[0];
    assign res_bit = ai ^ bi ^ bin_q;
    assign bout    = (~ai & bi) | (~(ai ^ bi) & bin_q);

    // Next-state: capture in IDLE, one full-subtractor step per RUN cycle, hold in DONE.
    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        diff_d     = diff_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                diff_d = {res_bit, diff_q[WIDTH-1:1]};
                bin_d  = bout;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d    = StDone;
                    borrow_d   = bout;
                    // On the last bit the shift registers hold the operand MSBs
                    // and res_bit is the result MSB.
                    overflow_d = (ai ^ bi) & (res_bit ^ ai);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    // State and registered handshake outputs; reset dominates everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            bin_q       <= 1'b0;
            borrow_q    <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            diff_q      <= diff_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            borrow_q    <= borrow_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;
    localparam int unsigned WIDTH = 8;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Accept one operation, scramble inputs while busy, optionally backpressure for
    // 'hold' cycles, then complete it and confirm the block is idle afterwards.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input int hold, input bit noisy, input logic [7:0] ed,
                          input logic eb, input logic eo);
        logic early;
        logic unstable;
        early    = 1'b0;
        unstable = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.out_ready = (hold == 0);
        step();  // accept edge
        check_eq({tag, " busy after accept"}, {31'b0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            if (noisy) bus.in_valid = ~bus.in_valid;
            step();
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) early = 1'b1;
        end
        check_eq({tag, " no early valid"}, {31'b0, early}, 32'd0);
        step();
        check_eq({tag, " out_valid"}, {31'b0, bus.out_valid}, 32'd1);
        check_eq({tag, " diff"}, {24'b0, bus.diff}, {24'b0, ed});
        check_eq({tag, " borrow"}, {31'b0, bus.borrow}, {31'b0, eb});
        check_eq({tag, " overflow"}, {31'b0, bus.overflow}, {31'b0, eo});
        for (int i = 0; i < hold; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            if (noisy) bus.in_valid = ~bus.in_valid;
            step();
            if (bus.out_valid !== 1'b1 || bus.diff !== ed || bus.borrow !== eb ||
                bus.overflow !== eo || bus.in_ready !== 1'b0) unstable = 1'b1;
        end
        if (hold > 0) check_eq({tag, " held under backpressure"}, {31'b0, unstable}, 32'd0);
        bus.in_valid  = noisy;
        bus.out_ready = 1'b1;
        step();  // completion edge
        check_eq({tag, " valid drops"}, {31'b0, bus.out_valid}, 32'd0);
        check_eq({tag, " ready after done"}, {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b0;
        step();
        check_eq({tag, " no extra accept"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic seen;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        check_eq("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        check_eq("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("reset diff", {24'b0, bus.diff}, 32'd0);
        check_eq("reset flags", {30'b0, bus.borrow, bus.overflow}, 32'd0);
        reset = 1'b0;
        step();

        run_op("100-37", 8'd100, 8'd37, 0, 1'b0, 8'd63, 1'b0, 1'b0);
        run_op("00-01", 8'h00, 8'h01, 0, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("80-01", 8'h80, 8'h01, 0, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("7F-FF bp", 8'h7F, 8'hFF, 5, 1'b0, 8'h80, 1'b1, 1'b1);

        // Abandon an operation with reset three edges after accept.
        bus.in_valid = 1'b1;
        bus.a        = 8'h55;
        bus.b        = 8'h11;
        step();
        bus.in_valid = 1'b0;
        seen         = 1'b0;
        step();
        if (bus.out_valid !== 1'b0) seen = 1'b1;
        step();
        if (bus.out_valid !== 1'b0) seen = 1'b1;
        reset = 1'b1;
        step();
        check_eq("abort in_ready", {31'b0, bus.in_ready}, 32'd1);
        check_eq("abort out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("abort diff cleared", {24'b0, bus.diff}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen = 1'b1;
        end
        check_eq("abort no result", {31'b0, seen}, 32'd0);

        run_op("5-5", 8'd5, 8'd5, 0, 1'b0, 8'd0, 1'b0, 1'b0);
        run_op("3C-A5 noisy", 8'h3C, 8'hA5, 3, 1'b1, 8'h97, 1'b1, 1'b1);
        run_op("C8-64 noisy", 8'hC8, 8'h64, 0, 1'b1, 8'h64, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
